// File: rtl/layer_sequencer_if.sv
// Host register bus plus neuron start/ready bundle for the layer sequencer.
interface layer_sequencer_if #(
   parameter int NUM_NEURONS = 4,
   parameter int LAYER_W     = 4
);
   logic [1:0]             address;
   logic                   write;
   logic [31:0]            writedata;
   logic [31:0]            readdata;
   logic [NUM_NEURONS-1:0] neuron_start;
   logic [NUM_NEURONS-1:0] neuron_ready;
   logic [LAYER_W-1:0]     layer_sel;
   logic                   irq;

   modport slave (
      input  address, write, writedata, neuron_ready,
      output readdata, neuron_start, layer_sel, irq
   );

   modport master (
      output address, write, writedata, neuron_ready,
      input  readdata, neuron_start, layer_sel, irq
   );
endinterface

// File: rtl/layer_sequencer.sv
// Steps NUM_LAYERS layers: start pulse to all neurons, wait for every ready, then next layer; readdata 1-cycle latency, no backpressure.
// Optional per-layer watchdog enabled by LAYER_SEQUENCER_TIMEOUT_EN.
module layer_sequencer #(
   parameter int NUM_NEURONS = 4,
   parameter int LAYER_W     = 4,
   parameter int TIMEOUT_W   = 16
) (
   input logic              clk,
   input logic              reset,
   layer_sequencer_if.slave bus
);

   if (NUM_NEURONS < 1 || NUM_NEURONS > 32 || LAYER_W < 1 || LAYER_W > 24 ||
       TIMEOUT_W < 1 || TIMEOUT_W > 32) begin : g_param_check
      $error("layer_sequencer: parameter out of range");
   end

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;

   state_t                 state_q, state_d;
   logic [LAYER_W-1:0]     layer_sel_q, layer_sel_d;
   logic [LAYER_W-1:0]     num_layers_q, num_layers_d;
   logic [LAYER_W-1:0]     last_layer;
   logic                   irq_en_q, irq_en_d;
   logic                   done_q, done_d;
   logic [NUM_NEURONS-1:0] mask_q, mask_d, mask_nxt;
   logic [31:0]            rdata_q, rdata_d;
   logic                   wr_ctrl, wr_status, start_req, abort_req;
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
   logic                   timeout_q, timeout_d;
   logic [TIMEOUT_W-1:0]   tlimit_q, tlimit_d;
   logic [TIMEOUT_W-1:0]   tcnt_q, tcnt_d;
`endif

   assign wr_ctrl   = bus.write && (bus.address == 2'd0);
   assign wr_status = bus.write && (bus.address == 2'd1);
   // ABORT outranks a START carried in the same write
   assign abort_req = wr_ctrl && bus.writedata[2];
   assign start_req = wr_ctrl && bus.writedata[0] && !bus.writedata[2];
   assign last_layer = (num_layers_q == '0) ? '0 : num_layers_q - 1'b1;
   assign mask_nxt   = mask_q | bus.neuron_ready;

   always_comb begin
      state_d      = state_q;
      layer_sel_d  = layer_sel_q;
      num_layers_d = num_layers_q;
      irq_en_d     = irq_en_q;
      done_d       = done_q;
      mask_d       = mask_q;
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
      timeout_d    = timeout_q;
      tlimit_d     = tlimit_q;
      tcnt_d       = tcnt_q;
      if (bus.write && (bus.address == 2'd3)) begin
         tlimit_d = bus.writedata[TIMEOUT_W-1:0];
      end
      if (wr_status && bus.writedata[2]) begin
         timeout_d = 1'b0;
      end
`endif
      if (wr_ctrl) begin
         irq_en_d     = bus.writedata[1];
         num_layers_d = bus.writedata[8 +: LAYER_W];
      end
      if (wr_status && bus.writedata[1]) begin
         done_d = 1'b0;
      end

      // FSM updates follow the W1C so a same-cycle set wins
      if (abort_req && (state_q != IDLE)) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_req) begin
                  layer_sel_d = '0;
                  done_d      = 1'b0;
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
                  timeout_d   = 1'b0;
`endif
                  state_d     = ISSUE;
               end
            end
            ISSUE: begin
               mask_d  = '0;
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
               tcnt_d  = '0;
`endif
               state_d = WAIT;
            end
            WAIT: begin
               mask_d = mask_nxt;
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
               tcnt_d = tcnt_q + 1'b1;
               if (&mask_nxt) begin
                  state_d = NEXT;
               end else if ((tlimit_q != '0) && (tcnt_d == tlimit_q)) begin
                  timeout_d = 1'b1;
                  done_d    = 1'b1;
                  state_d   = IDLE;
               end
`else
               if (&mask_nxt) begin
                  state_d = NEXT;
               end
`endif
            end
            NEXT: begin
               if (layer_sel_q == last_layer) begin
                  state_d = DONE;
               end else begin
                  layer_sel_d = layer_sel_q + 1'b1;
                  state_d     = ISSUE;
               end
            end
            DONE: begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      rdata_d = '0;
      unique case (bus.address)
         2'd0: begin
            rdata_d[1]            = irq_en_q;
            rdata_d[8 +: LAYER_W] = num_layers_q;
         end
         2'd1: begin
            rdata_d[0]            = (state_q != IDLE);
            rdata_d[1]            = done_q;
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
            rdata_d[2]            = timeout_q;
`endif
            rdata_d[8 +: LAYER_W] = layer_sel_q;
         end
         2'd2: rdata_d[NUM_NEURONS-1:0] = mask_q;
         default: begin
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
            rdata_d[TIMEOUT_W-1:0] = tlimit_q;
`endif
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         layer_sel_q  <= '0;
         num_layers_q <= '0;
         irq_en_q     <= 1'b0;
         done_q       <= 1'b0;
         mask_q       <= '0;
         rdata_q      <= '0;
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
         timeout_q    <= 1'b0;
         tlimit_q     <= '0;
         tcnt_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         layer_sel_q  <= layer_sel_d;
         num_layers_q <= num_layers_d;
         irq_en_q     <= irq_en_d;
         done_q       <= done_d;
         mask_q       <= mask_d;
         rdata_q      <= rdata_d;
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
         timeout_q    <= timeout_d;
         tlimit_q     <= tlimit_d;
         tcnt_q       <= tcnt_d;
`endif
      end
   end

   assign bus.readdata     = rdata_q;
   assign bus.layer_sel    = layer_sel_q;
   assign bus.neuron_start = ((state_q == ISSUE) && !abort_req) ? '1 : '0;
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
   assign bus.irq          = (done_q | timeout_q) & irq_en_q;
`else
   assign bus.irq          = done_q & irq_en_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: expected start pulses queued per run, popped as pulses appear.
module tb_layer_sequencer;
   localparam int NM_MANUAL = 0;
   localparam int NM_AUTO   = 1;
   localparam int NM_PART   = 2;
   localparam int NM_HOLD   = 3;

   logic clk;
   logic reset;
   layer_sequencer_if #(.NUM_NEURONS(4), .LAYER_W(4)) bus ();

   layer_sequencer #(.NUM_NEURONS(4), .LAYER_W(4), .TIMEOUT_W(16)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int         n_tests = 0;
   int         n_fail  = 0;
   int         pulses  = 0;
   int         pushed  = 0;
   int         cyc     = 0;
   int         last_cyc = 0;
   int         last_gap = 0;
   int         nmode   = NM_MANUAL;
   logic [3:0] man_ready = '0;
   logic [3:0] mdl_ready = '0;
   logic [3:0] exp_q[$];

   assign bus.neuron_ready = (nmode == NM_MANUAL) ? man_ready : mdl_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic host_wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      bus.address = a; bus.write = 1'b1; bus.writedata = d;
      @(posedge clk); #1;
      bus.write = 1'b0; bus.writedata = '0;
   endtask

   task automatic host_rd(input logic [1:0] a, output logic [31:0] d);
      @(posedge clk); #1;
      bus.address = a;
      @(posedge clk); #1;
      d = bus.readdata;
   endtask

   task automatic push_layers(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(4'(i));
      pushed += n;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      logic [31:0] d;
      bit ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         host_rd(2'd1, d);
         if (!d[0]) begin ok = 1'b1; break; end
      end
      if (!ok) chk({tag, "_idle_timeout"}, d, 32'(d & ~32'h1));
   endtask

   task automatic wait_layer_pulse(input string tag, input logic [3:0] layer);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.neuron_start != '0 && bus.layer_sel == layer) begin ok = 1'b1; break; end
         @(posedge clk); #1;
      end
      if (!ok) chk({tag, "_pulse_timeout"}, 32'(bus.layer_sel), 32'(layer));
   endtask

   // Neuron model: raises ready 5 cycles after each start pulse
   initial begin
      int cd = -1;
      forever begin
         @(posedge clk); #1;
         if (nmode == NM_HOLD) begin
            mdl_ready = '1;
         end else if (bus.neuron_start != '0) begin
            mdl_ready = '0;
            cd = 5;
         end else if (cd > 0) begin
            cd--;
            if (cd == 0) mdl_ready = (nmode == NM_PART) ? 4'h7 : 4'hF;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && bus.neuron_start != '0) begin
         pulses++;
         last_gap = cyc - last_cyc;
         last_cyc = cyc;
         chk("start_pattern", 32'(bus.neuron_start), 32'hF);
         chk("start_pending", 32'(exp_q.size() != 0), 32'h1);
         if (exp_q.size() != 0) chk("start_layer", 32'(bus.layer_sel), 32'(exp_q.pop_front()));
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [3:0]  stag_bit [4] = '{4'h1, 4'h4, 4'h2, 4'h8};
      logic [31:0] stag_exp [4] = '{32'h1, 32'h5, 32'h7, 32'hF};
      bus.address = '0; bus.write = 1'b0; bus.writedata = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk); #1;
      chk("rst_start", 32'(bus.neuron_start), 32'h0);
      chk("rst_lsel", 32'(bus.layer_sel), 32'h0);
      chk("rst_irq", 32'(bus.irq), 32'h0);
      chk("rst_rdata", bus.readdata, 32'h0);
      reset = 1'b0;
      host_rd(2'd1, d); chk("rst_status", d, 32'h0);

      // basic three-layer run
      nmode = NM_AUTO;
      host_wr(2'd0, 32'h0302);
      push_layers(3);
      host_wr(2'd0, 32'h0303);
      wait_idle("basic", 200);
      host_rd(2'd1, d); chk("basic_status", d, 32'h0202);
      chk("basic_irq", 32'(bus.irq), 32'h1);
      chk("basic_pulses", 32'(pulses), 32'(pushed));
      host_wr(2'd1, 32'h2);
      chk("basic_irq_clr", 32'(bus.irq), 32'h0);

      // staggered ready
      nmode = NM_MANUAL; man_ready = '0;
      push_layers(1);
      host_wr(2'd0, 32'h0103);
      wait_layer_pulse("stag", 4'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
         man_ready = stag_bit[i];
         @(posedge clk); #1;
         man_ready = '0;
         host_rd(2'd2, d); chk("stag_mask", d, stag_exp[i]);
         if (i < 3) begin
            host_rd(2'd1, d); chk("stag_busy", d, 32'h1);
         end
      end
      wait_idle("stag", 50);
      host_rd(2'd1, d); chk("stag_status", d, 32'h2);

      // NUM_LAYERS=0 runs a single layer
      nmode = NM_AUTO;
      push_layers(1);
      host_wr(2'd0, 32'h0003);
      wait_idle("nl0", 100);
      host_rd(2'd1, d); chk("nl0_status", d, 32'h2);
      chk("nl0_pulses", 32'(pulses), 32'(pushed));

      // NUM_LAYERS=15 with ready held high
      nmode = NM_HOLD;
      @(posedge clk); #1;
      push_layers(15);
      host_wr(2'd0, 32'h0F03);
      wait_idle("nl15", 300);
      host_rd(2'd1, d); chk("nl15_status", d, 32'h0E02);
      chk("nl15_lsel", 32'(bus.layer_sel), 32'hE);
      chk("nl15_gap", 32'(last_gap), 32'h3);
      chk("nl15_pulses", 32'(pulses), 32'(pushed));

      // START while busy is ignored
      nmode = NM_AUTO;
      push_layers(2);
      host_wr(2'd0, 32'h0203);
      repeat (4) @(posedge clk);
      host_wr(2'd0, 32'h0203);
      wait_idle("busy", 200);
      repeat (10) @(posedge clk); #1;
      chk("busy_pulses", 32'(pulses), 32'(pushed));
      host_rd(2'd1, d); chk("busy_status", d, 32'h0102);

      // ABORT in WAIT of layer 1
      push_layers(2);
      host_wr(2'd0, 32'h0303);
      wait_layer_pulse("abort", 4'd1);
      host_wr(2'd0, 32'h0306);
      host_rd(2'd1, d); chk("abort_status", d, 32'h0100);
      chk("abort_irq", 32'(bus.irq), 32'h0);
      repeat (30) @(posedge clk); #1;
      chk("abort_pulses", 32'(pulses), 32'(pushed));

      // per-layer watchdog, neuron 3 never ready
      nmode = NM_PART;
      host_wr(2'd3, 32'd10);
`ifdef LAYER_SEQUENCER_TIMEOUT_EN
      host_rd(2'd3, d); chk("to_limit_rb", d, 32'd10);
      push_layers(1);
      host_wr(2'd0, 32'h0103);
      wait_layer_pulse("to", 4'd0);
      repeat (10) @(posedge clk); #1;
      chk("to_irq_before", 32'(bus.irq), 32'h0);
      @(posedge clk); #1;
      chk("to_irq_after", 32'(bus.irq), 32'h1);
      host_rd(2'd1, d); chk("to_status", d, 32'h6);
      host_wr(2'd1, 32'h6);
      chk("to_irq_clr", 32'(bus.irq), 32'h0);
`else
      host_rd(2'd3, d); chk("to_limit_rb", d, 32'h0);
      push_layers(1);
      host_wr(2'd0, 32'h0103);
      repeat (100) @(posedge clk);
      host_rd(2'd1, d); chk("to_stuck_status", d, 32'h1);
      chk("to_stuck_irq", 32'(bus.irq), 32'h0);
      host_wr(2'd0, 32'h0106);
      host_rd(2'd1, d); chk("to_abort_status", d, 32'h0);
`endif

      // asynchronous reset mid-WAIT of layer 1
      nmode = NM_AUTO;
      push_layers(3);
      host_wr(2'd0, 32'h0303);
      wait_layer_pulse("rst2", 4'd1);
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("rst2_start", 32'(bus.neuron_start), 32'h0);
      chk("rst2_lsel", 32'(bus.layer_sel), 32'h0);
      chk("rst2_irq", 32'(bus.irq), 32'h0);
      chk("rst2_rdata", bus.readdata, 32'h0);
      exp_q.delete();
      pushed = pulses;
      nmode = NM_MANUAL; man_ready = '0;
      @(posedge clk); #1;
      reset = 1'b0;
      host_rd(2'd1, d); chk("rst2_status", d, 32'h0);
      host_rd(2'd0, d); chk("rst2_ctrl", d, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
